// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: issues PC-ordered imem requests and buffers returned
// instructions in an in-order show-ahead queue feeding decode.
module fetch_prefetch_queue #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 4,
  parameter int                MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter int                PC_STEP    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold_pc,
  input  logic                       hold_if,
  input  logic                       br,
  input  logic [ADDR_W-1:0]          pc_branch,
  input  logic                       except,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_valid,
  input  logic [DATA_W-1:0]          imem_data,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [DATA_W-1:0]          inst_out,
  output logic                       inst_valid,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t            q_mem   [DEPTH];
  logic [ADDR_W-1:0] tag_mem [MAX_OUTST];

  logic [ADDR_W-1:0] pc, last_pc, target;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [TW-1:0]     tag_wr, tag_rd;
  logic [CW-1:0]     count, outst, discard;
  logic [CW:0]       slots;
  logic              redirect, push, pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
  endfunction

  assign redirect = br | except;
  assign target   = except ? EXC_VECTOR : pc_branch;

  // Queue slots are reserved at issue time, so responses never need back-pressure.
  assign slots    = {1'b0, count} + {1'b0, outst};
  assign imem_req = !rst && !redirect && !hold_pc &&
                    (outst < CW'(MAX_OUTST)) && (slots < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  assign inst_valid = (count != '0);
  assign push       = imem_valid && (discard == '0) && !redirect;
  assign pop        = inst_valid && !hold_if && !redirect;

  assign pc_out   = inst_valid ? q_mem[rd_ptr].pc : last_pc;
  assign inst_out = inst_valid ? q_mem[rd_ptr].inst : '0;
  assign q_count  = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      last_pc <= '0;
      outst   <= '0;
      discard <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      tag_wr  <= '0;
      tag_rd  <= '0;
    end else begin
      outst <= outst + CW'(imem_req) - CW'(imem_valid);
      if (imem_req)   tag_wr  <= tag_inc(tag_wr);
      if (imem_valid) tag_rd  <= tag_inc(tag_rd);
      if (pop)        last_pc <= q_mem[rd_ptr].pc;
      if (redirect) begin
        // Everything still in flight belongs to the old path; drop it on return.
        pc      <= target;
        discard <= outst - CW'(imem_valid);
        count   <= '0;
        rd_ptr  <= wr_ptr;
      end else begin
        if (imem_req) pc <= pc + ADDR_W'(PC_STEP);
        if (imem_valid && (discard != '0)) discard <= discard - CW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) tag_mem[tag_wr] <= pc;
    if (push)     q_mem[wr_ptr]   <= '{pc: tag_mem[tag_rd], inst: imem_data};
  end

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst) imem_valid |-> (outst != '0));
  a_count_bound:     assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_outst_bound:     assert property (@(posedge clk) disable iff (rst) outst <= CW'(MAX_OUTST));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int MO    = 2;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 0, rst;
  logic        hold_pc, hold_if, br, except;
  logic [31:0] pc_branch;
  logic        imem_req, imem_valid, inst_valid;
  logic [31:0] imem_addr, imem_data, pc_out, inst_out;
  logic [2:0]  q_count;

  logic        req2, valid2, iv2;
  logic [31:0] addr2, data2, pc_out2, inst_out2;
  logic [2:0]  qc2;

  always #5 clk = ~clk;

  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst), .hold_pc(hold_pc), .hold_if(hold_if), .br(br),
    .pc_branch(pc_branch), .except(except), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .pc_out(pc_out), .inst_out(inst_out),
    .inst_valid(inst_valid), .q_count(q_count));

  fetch_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .hold_pc(1'b0), .hold_if(1'b0), .br(1'b0),
    .pc_branch(32'h0), .except(1'b0), .imem_req(req2), .imem_addr(addr2),
    .imem_valid(valid2), .imem_data(data2), .pc_out(pc_out2), .inst_out(inst_out2),
    .inst_valid(iv2), .q_count(qc2));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: fetched entries, in-flight tags with a stale flag, PC.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; logic stale; } fl_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  ent_t  mq[$];
  fl_t   mf[$];
  pend_t mem[$];
  logic [31:0] m_pc, m_last;
  logic [31:0] wlog[$];
  logic        pend2;
  logic [31:0] pend2_addr;
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;
  int          s_cnt;

  task automatic m_reset();
    mq.delete(); mf.delete();
    m_pc = 32'h0; m_last = 32'h0;
  endtask

  task automatic cycle();
    logic redir, e_req, e_valid, do_pop;
    fl_t  f;
    int   due;
    if (mem.size() > 0 && mem[0].due <= cyc) begin
      imem_valid = 1; imem_data = mem[0].addr;
    end else begin
      imem_valid = 0; imem_data = $urandom;
    end
    valid2 = pend2; data2 = pend2_addr;
    @(negedge clk);
    if (rst) m_reset();
    redir   = br | except;
    e_req   = !rst && !redir && !hold_pc && (mf.size() < MO) && (mq.size() + mf.size() < DEPTH);
    e_valid = mq.size() > 0;
    chk("imem_req", imem_req, e_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, e_valid);
    chk("pc_out", pc_out, e_valid ? mq[0].pc : m_last);
    chk("inst_out", inst_out, e_valid ? mq[0].inst : 32'h0);
    chk("q_count", q_count, mq.size());
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
    s_pc = pc_out; s_inst = inst_out; s_cnt = int'(q_count);
    if (imem_valid) void'(mem.pop_front());
    if (imem_req) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem.push_back('{imem_addr, due});
    end
    pend2 = req2 && !rst; pend2_addr = addr2;
    if (rst) wlog.delete();
    else if (req2 && wlog.size() < 3) wlog.push_back(addr2);
    if (!rst) begin
      do_pop = e_valid && !hold_if && !redir;
      if (do_pop) begin m_last = mq[0].pc; void'(mq.pop_front()); end
      if (imem_valid && mf.size() > 0) begin
        f = mf.pop_front();
        if (!f.stale && !redir) mq.push_back('{f.addr, imem_data});
      end
      if (redir) begin
        mq.delete();
        foreach (mf[i]) mf[i].stale = 1'b1;
        m_pc = except ? EXC : pc_branch;
      end else if (e_req) begin
        mf.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic clear_inputs();
    hold_pc = 0; hold_if = 0; br = 0; except = 0; pc_branch = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    cycle(); cycle();
    rst = 0; mem.delete(); pend2 = 0;
  endtask

  typedef struct {
    bit rst_before; bit hold_if;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; int e_cnt;
  } vec_t;
  vec_t tbl[$];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int maxo, pops, bad, n;
    logic [31:0] prev;
    bit found;
    rst = 1; clear_inputs(); imem_valid = 0; imem_data = 0; pend2 = 0; pend2_addr = 0;
    valid2 = 0; data2 = 0;
    m_reset();
    @(posedge clk); #1;

    // Straight-line fetch, latency 1, then queue saturation under decode stall.
    tbl.push_back('{1, 0, 1, 32'd0,  0, 32'd0, 0});
    tbl.push_back('{0, 0, 1, 32'd4,  0, 32'd0, 0});
    tbl.push_back('{0, 0, 1, 32'd8,  1, 32'd0, 1});
    tbl.push_back('{0, 0, 1, 32'd12, 1, 32'd4, 1});
    tbl.push_back('{0, 0, 1, 32'd16, 1, 32'd8, 1});
    tbl.push_back('{0, 0, 1, 32'd20, 1, 32'd12, 1});
    tbl.push_back('{1, 1, 1, 32'd0,  0, 32'd0, 0});
    tbl.push_back('{0, 1, 1, 32'd4,  0, 32'd0, 0});
    tbl.push_back('{0, 1, 1, 32'd8,  1, 32'd0, 1});
    tbl.push_back('{0, 1, 1, 32'd12, 1, 32'd0, 2});
    tbl.push_back('{0, 1, 0, 32'd16, 1, 32'd0, 3});
    for (int k = 0; k < 5; k++) tbl.push_back('{0, 1, 0, 32'd16, 1, 32'd0, 4});
    tbl.push_back('{0, 0, 0, 32'd16, 1, 32'd0, 4});
    tbl.push_back('{0, 0, 1, 32'd16, 1, 32'd4, 3});
    tbl.push_back('{0, 0, 1, 32'd20, 1, 32'd8, 2});
    tbl.push_back('{0, 0, 1, 32'd24, 1, 32'd12, 2});
    tbl.push_back('{0, 0, 1, 32'd28, 1, 32'd16, 2});

    lat_min = 1; lat_max = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) begin
        if (i > 0) begin
          chk("wrap_n", wlog.size(), 3);
          if (wlog.size() == 3) begin
            chk("wrap_a0", wlog[0], 32'hFFFF_FFF8);
            chk("wrap_a1", wlog[1], 32'hFFFF_FFFC);
            chk("wrap_a2", wlog[2], 32'h0000_0000);
          end
        end
        do_reset();
      end
      hold_if = tbl[i].hold_if;
      cycle();
      chk($sformatf("t%0d_req", i),   s_req,   tbl[i].e_req);
      chk($sformatf("t%0d_addr", i),  s_addr,  tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), s_valid, tbl[i].e_valid);
      chk($sformatf("t%0d_pc", i),    s_pc,    tbl[i].e_pc);
      chk($sformatf("t%0d_cnt", i),   s_cnt,   tbl[i].e_cnt);
    end

    // Latency 2: at most two in flight, popped PCs strictly sequential.
    lat_min = 2; lat_max = 2;
    do_reset();
    maxo = 0; pops = 0; bad = 0; prev = 32'hFFFF_FFFC;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (mem.size() > maxo) maxo = mem.size();
      if (s_valid) begin
        if (s_pc != prev + 32'd4) bad++;
        prev = s_pc; pops++;
      end
    end
    chk("lat2_max_outst", maxo, 2);
    chk("lat2_contig_errs", bad, 0);
    chk("lat2_enough_pops", pops >= 10, 1);

    // Branch with two requests outstanding.
    do_reset();
    cycle(); cycle();
    chk("br_outst", mem.size(), 2);
    br = 1; pc_branch = 32'h100;
    cycle();
    chk("br_req_t", s_req, 0);
    br = 0; pc_branch = 32'h0;
    cycle();
    chk("br_req_t1", s_req, 1);
    chk("br_addr_t1", s_addr, 32'h100);
    chk("br_cnt_t1", s_cnt, 0);
    found = 0; n = 0;
    while (!found && n < 20) begin
      cycle(); n++;
      if (s_valid) begin found = 1; chk("br_first_pc", s_pc, 32'h100); end
    end
    chk("br_valid_seen", found, 1);

    // Branch and exception together: exception vector wins.
    do_reset();
    cycle(); cycle();
    br = 1; except = 1; pc_branch = 32'h40;
    cycle();
    br = 0; except = 0; pc_branch = 32'h0;
    cycle();
    chk("exc_req", s_req, 1);
    chk("exc_addr", s_addr, EXC);

    // Asynchronous reset mid-stream with two outstanding.
    do_reset();
    hold_if = 1;
    for (int k = 0; k < 5; k++) cycle();
    chk("rst_pre_outst", mem.size(), 2);
    chk("rst_pre_valid", inst_valid, 1);
    rst = 1;
    #1;
    chk("rst_async_valid", inst_valid, 0);
    chk("rst_async_cnt", q_count, 0);
    chk("rst_async_req", imem_req, 0);
    chk("rst_async_inst", inst_out, 0);
    for (int k = 0; k < 3; k++) cycle();
    rst = 0; hold_if = 0; mem.delete(); pend2 = 0;
    cycle();
    chk("rst_first_req", s_req, 1);
    chk("rst_first_addr", s_addr, 32'h0);
    for (int k = 0; k < 8; k++) cycle();

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      hold_pc   = ($urandom_range(99) < 25);
      hold_if   = ($urandom_range(99) < 30);
      br        = ($urandom_range(99) < 5);
      except    = ($urandom_range(99) < 2);
      pc_branch = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
